posit_mult_arbiter: RTL and testbench

- Shares one posit multiplier datapath (32-bit operands in, 32-bit result plus inf/zero flags out) between NREQ independent requesters.
- Round-robin arbitration; at most one issue per cycle.
- Each in-flight operation is tagged with its requester index, and the returned result is steered into that requester's result FIFO.
- Per-requester credit counters make result-FIFO overflow impossible by construction.

---
 rtl/posit_mult_arbiter.sv | 169 ++++++++++++++++
 tb/tb_posit_mult_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_mult_arbiter.sv
// posit_mult_arbiter: several requesters share one posit multiplier.
// Requests are granted round-robin, one issue per cycle. Each operation
// carries a requester tag through a shift pipeline that matches the
// multiplier latency, so the result lands in the right requester's FIFO.
// A requester is granted only while it holds a credit, and it holds one
// credit per free slot in its FIFO, so the FIFOs cannot overflow.
module posit_mult_arbiter #(
  parameter int NREQ         = 4,
  parameter int MULT_LATENCY = 0,
  parameter int RES_DEPTH    = 2,
  parameter int NBITS        = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*NBITS-1:0] req_in1,
  input  logic [NREQ*NBITS-1:0] req_in2,
  output logic [NREQ-1:0]       res_valid,
  input  logic [NREQ-1:0]       res_ready,
  output logic [NREQ*NBITS-1:0] res_data,
  output logic [NREQ-1:0]       res_inf,
  output logic [NREQ-1:0]       res_zero,
  output logic                  mult_start,
  output logic [NBITS-1:0]      mult_in1,
  output logic [NBITS-1:0]      mult_in2,
  input  logic [NBITS-1:0]      mult_result,
  input  logic                  mult_inf,
  input  logic                  mult_zero,
  input  logic                  mult_done,
  output logic                  busy,
  output logic                  err_done
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int EW = NBITS + 2;

  logic [NREQ-1:0] elig, grant, push, drop, pop;
  logic [IW-1:0]   ptr, gnt_idx, cand, iss_tag, exp_tag;
  logic            found, iss_vld, exp_vld, pipe_any;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RES_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Round-robin search upward from the slot after the last winner.
  always_comb begin
    grant   = '0;
    gnt_idx = ptr;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && elig[cand]) begin
        found        = 1'b1;
        grant[cand]  = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

  assign req_ready  = grant;
  assign mult_start = iss_vld;

  // Issue register, RR pointer and sticky protocol-error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= IW'(NREQ - 1);
      iss_vld  <= 1'b0;
      iss_tag  <= '0;
      mult_in1 <= '0;
      mult_in2 <= '0;
      err_done <= 1'b0;
    end else begin
      iss_vld <= found;
      if (found) begin
        ptr      <= gnt_idx;
        iss_tag  <= gnt_idx;
        mult_in1 <= req_in1[int'(gnt_idx)*NBITS +: NBITS];
        mult_in2 <= req_in2[int'(gnt_idx)*NBITS +: NBITS];
      end
      // A done without an expected tag, or an expected tag without a done.
      if (mult_done != exp_vld) err_done <= 1'b1;
    end
  end

  // Tag pipeline: the last stage names the op whose result is due now.
  if (MULT_LATENCY == 0) begin : g_lat0
    assign exp_vld  = iss_vld;
    assign exp_tag  = iss_tag;
    assign pipe_any = 1'b0;
  end else begin : g_pipe
    logic [MULT_LATENCY-1:0]         vld_pipe;
    logic [MULT_LATENCY-1:0][IW-1:0] tag_pipe;

    // Shift {valid, tag} one stage per cycle behind the issue register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_pipe <= '0;
        tag_pipe <= '0;
      end else begin
        vld_pipe[0] <= iss_vld;
        tag_pipe[0] <= iss_tag;
        for (int s = 1; s < MULT_LATENCY; s++) begin
          vld_pipe[s] <= vld_pipe[s-1];
          tag_pipe[s] <= tag_pipe[s-1];
        end
      end
    end

    assign exp_vld  = vld_pipe[MULT_LATENCY-1];
    assign exp_tag  = tag_pipe[MULT_LATENCY-1];
    assign pipe_any = |vld_pipe;
  end

  assign busy = iss_vld | pipe_any | (|res_valid);

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    logic [CW-1:0]               credit, cnt;
    logic [PW-1:0]               rd_ptr, wr_ptr;
    logic [RES_DEPTH-1:0][EW-1:0] mem;
    logic [EW-1:0]               head;

    // Reset gates eligibility so req_ready stays low while held in reset.
    assign elig[i]      = reset_n & req_valid[i] & (credit != '0);
    assign push[i]      = mult_done & exp_vld & (exp_tag == IW'(i));
    assign drop[i]      = ~mult_done & exp_vld & (exp_tag == IW'(i));
    assign res_valid[i] = (cnt != '0);
    assign pop[i]       = res_valid[i] & res_ready[i];

    assign head                     = mem[rd_ptr];
    assign res_data[i*NBITS +: NBITS] = head[EW-1:2];
    assign res_inf[i]               = head[1];
    assign res_zero[i]              = head[0];

    // Credits + ops in flight + FIFO occupancy always sum to RES_DEPTH,
    // so this update never leaves 0..RES_DEPTH. A dropped (missed) result
    // hands its credit back since it never occupies a slot.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) credit <= CW'(RES_DEPTH);
      else          credit <= credit - CW'(grant[i]) + CW'(pop[i]) + CW'(drop[i]);
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[i]) wr_ptr <= ptr_inc(wr_ptr);
        if (pop[i])  rd_ptr <= ptr_inc(rd_ptr);
        cnt <= cnt + CW'(push[i]) - CW'(pop[i]);
      end
    end

    // FIFO storage; contents are don't-care until cnt covers them.
    always_ff @(posedge clk) begin
      if (push[i]) mem[wr_ptr] <= {mult_result, mult_inf, mult_zero};
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(push[i] && cnt == CW'(RES_DEPTH)));
    a_credit_range: assert property (@(posedge clk) disable iff (!reset_n)
      credit <= CW'(RES_DEPTH));
  end

endmodule

// File: tb/tb_posit_mult_arbiter.sv
// Bench for posit_mult_arbiter: two instances (latency 0 and latency 3)
// share requester stimulus; each has its own multiplier stand-in and its
// own transaction-level reference model (credits, RR pointer, queues).
module tb_posit_mult_arbiter;
  localparam int NREQ = 4;
  localparam int NB   = 32;
  localparam int RD   = 2;

  typedef struct {
    int          tag;
    int          due;
    logic [31:0] a;
    logic [31:0] b;
  } pend_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic inj = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    res_ready = '0;
  logic [NREQ*NB-1:0] req_in1 = '0;
  logic [NREQ*NB-1:0] req_in2 = '0;

  logic [NREQ-1:0]    rr_w [2];
  logic [NREQ-1:0]    rv_w [2];
  logic [NREQ-1:0]    rinf_w [2];
  logic [NREQ-1:0]    rzero_w [2];
  logic [NREQ*NB-1:0] rdata_w [2];
  logic               mstart_w [2];
  logic               mdone_w [2];
  logic               minf_w [2];
  logic               mzero_w [2];
  logic               busy_w [2];
  logic               err_w [2];
  logic [NB-1:0]      min1_w [2];
  logic [NB-1:0]      min2_w [2];
  logic [NB-1:0]      mres_w [2];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model state, index 0 = latency-0 instance, 1 = latency-3.
  int          m_cred [2][NREQ];
  int          m_ptr [2];
  logic        m_iss [2];
  int          m_tag [2];
  logic [31:0] m_a [2];
  logic [31:0] m_b [2];
  logic        m_err [2];
  pend_t       pq [2][$];
  logic [33:0] fq [2][NREQ][$];

  always #5 clk = ~clk;

  // Stand-in multiplier: exact for 1.0*x, special-cases inf and zero.
  function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic inf, zero;
    inf  = (a == 32'h8000_0000) || (b == 32'h8000_0000);
    zero = !inf && (a == 32'h0 || b == 32'h0);
    if (inf)       return {32'h8000_0000, 2'b10};
    else if (zero) return {32'h0, 2'b01};
    else           return {a + b - 32'h4000_0000, 2'b00};
  endfunction

  posit_mult_arbiter #(.NREQ(NREQ), .MULT_LATENCY(0), .RES_DEPTH(RD), .NBITS(NB)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rr_w[0]),
    .req_in1(req_in1), .req_in2(req_in2), .res_valid(rv_w[0]), .res_ready(res_ready),
    .res_data(rdata_w[0]), .res_inf(rinf_w[0]), .res_zero(rzero_w[0]),
    .mult_start(mstart_w[0]), .mult_in1(min1_w[0]), .mult_in2(min2_w[0]),
    .mult_result(mres_w[0]), .mult_inf(minf_w[0]), .mult_zero(mzero_w[0]),
    .mult_done(mdone_w[0]), .busy(busy_w[0]), .err_done(err_w[0]));

  posit_mult_arbiter #(.NREQ(NREQ), .MULT_LATENCY(3), .RES_DEPTH(RD), .NBITS(NB)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rr_w[1]),
    .req_in1(req_in1), .req_in2(req_in2), .res_valid(rv_w[1]), .res_ready(res_ready),
    .res_data(rdata_w[1]), .res_inf(rinf_w[1]), .res_zero(rzero_w[1]),
    .mult_start(mstart_w[1]), .mult_in1(min1_w[1]), .mult_in2(min2_w[1]),
    .mult_result(mres_w[1]), .mult_inf(minf_w[1]), .mult_zero(mzero_w[1]),
    .mult_done(mdone_w[1]), .busy(busy_w[1]), .err_done(err_w[1]));

  // Combinational core for the latency-0 instance.
  assign {mres_w[0], minf_w[0], mzero_w[0]} = fmul(min1_w[0], min2_w[0]);
  assign mdone_w[0] = mstart_w[0] | inj;

  // Three-cycle core for the latency-3 instance.
  logic [2:0]  dl_v;
  logic [31:0] dl_a [3];
  logic [31:0] dl_b [3];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_v <= '0;
      for (int s = 0; s < 3; s++) begin
        dl_a[s] <= '0;
        dl_b[s] <= '0;
      end
    end else begin
      dl_v    <= {dl_v[1:0], mstart_w[1]};
      dl_a[0] <= min1_w[1];
      dl_b[0] <= min2_w[1];
      for (int s = 1; s < 3; s++) begin
        dl_a[s] <= dl_a[s-1];
        dl_b[s] <= dl_b[s-1];
      end
    end
  end
  assign {mres_w[1], minf_w[1], mzero_w[1]} = fmul(dl_a[2], dl_b[2]);
  assign mdone_w[1] = dl_v[2] | inj;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NREQ; i++) begin
        m_cred[d][i] = RD;
        fq[d][i].delete();
      end
      m_ptr[d] = NREQ - 1;
      m_iss[d] = 1'b0;
      m_tag[d] = 0;
      m_a[d]   = '0;
      m_b[d]   = '0;
      m_err[d] = 1'b0;
      pq[d].delete();
    end
  endtask

  // One cycle of the reference model: compare outputs, then advance state.
  task automatic model_step(input int d);
    int gi, ptag, lat;
    logic [NREQ-1:0] g, rv;
    logic bz, have_push;
    logic [33:0] pval, h;
    pend_t p;
    lat = (d == 0) ? 0 : 3;
    if (m_iss[d]) pq[d].push_back('{m_tag[d], cyc + lat, m_a[d], m_b[d]});
    chk(d ? "mult_start_l3" : "mult_start_l0", 64'(mstart_w[d]), 64'(m_iss[d]));
    chk(d ? "mult_in1_l3" : "mult_in1_l0", 64'(min1_w[d]), 64'(m_a[d]));
    chk(d ? "mult_in2_l3" : "mult_in2_l0", 64'(min2_w[d]), 64'(m_b[d]));
    bz = m_iss[d] || (pq[d].size() > 0);
    for (int i = 0; i < NREQ; i++) begin
      rv[i] = fq[d][i].size() > 0;
      bz |= rv[i];
      if (rv[i]) begin
        h = fq[d][i][0];
        chk(d ? "res_data_l3" : "res_data_l0", 64'(rdata_w[d][i*NB +: NB]), 64'(h[33:2]));
        chk(d ? "res_inf_l3" : "res_inf_l0", 64'(rinf_w[d][i]), 64'(h[1]));
        chk(d ? "res_zero_l3" : "res_zero_l0", 64'(rzero_w[d][i]), 64'(h[0]));
      end
    end
    chk(d ? "res_valid_l3" : "res_valid_l0", 64'(rv_w[d]), 64'(rv));
    chk(d ? "busy_l3" : "busy_l0", 64'(busy_w[d]), 64'(bz));
    chk(d ? "err_done_l3" : "err_done_l0", 64'(err_w[d]), 64'(m_err[d]));
    gi = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (m_ptr[d] + k) % NREQ;
      if (gi < 0 && req_valid[j] && m_cred[d][j] > 0) gi = j;
    end
    g = '0;
    if (gi >= 0) g[gi] = 1'b1;
    chk(d ? "req_ready_l3" : "req_ready_l0", 64'(rr_w[d]), 64'(g));
    have_push = 1'b0;
    ptag = 0;
    pval = '0;
    if (pq[d].size() > 0 && pq[d][0].due == cyc) begin
      p = pq[d].pop_front();
      if (mdone_w[d]) begin
        have_push = 1'b1;
        ptag = p.tag;
        pval = fmul(p.a, p.b);
      end else begin
        m_err[d] = 1'b1;
        m_cred[d][p.tag]++;
      end
    end else if (mdone_w[d]) begin
      m_err[d] = 1'b1;
    end
    for (int i = 0; i < NREQ; i++)
      if (rv[i] && res_ready[i]) begin
        void'(fq[d][i].pop_front());
        m_cred[d][i]++;
      end
    if (have_push) fq[d][ptag].push_back(pval);
    m_iss[d] = (gi >= 0);
    if (gi >= 0) begin
      m_cred[d][gi]--;
      m_ptr[d] = gi;
      m_tag[d] = gi;
      m_a[d]   = req_in1[gi*NB +: NB];
      m_b[d]   = req_in2[gi*NB +: NB];
    end
  endtask

  // Checker: all outputs compared mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      model_reset();
      for (int d = 0; d < 2; d++) begin
        chk("rst_req_ready", 64'(rr_w[d]), 64'(0));
        chk("rst_res_valid", 64'(rv_w[d]), 64'(0));
        chk("rst_mult_start", 64'(mstart_w[d]), 64'(0));
        chk("rst_mult_in", {min1_w[d], min2_w[d]}, 64'(0));
        chk("rst_busy", 64'(busy_w[d]), 64'(0));
        chk("rst_err_done", 64'(err_w[d]), 64'(0));
      end
    end else begin
      for (int d = 0; d < 2; d++) model_step(d);
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'h4000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic rnd_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_in1[i*NB +: NB] = rnd_op();
      req_in2[i*NB +: NB] = rnd_op();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    req_valid = '0;
    res_ready = '1;
    while ((busy_w[0] || busy_w[1]) && n < 100) begin
      step();
      n++;
    end
    chk("idle_timeout", 64'(n >= 100), 64'(0));
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) step();

    // 1.0 * 2.0 from requester 0 right after reset release.
    reset_n   = 1'b1;
    res_ready = '1;
    req_valid = 4'b0001;
    req_in1[0 +: NB] = 32'h4000_0000;
    req_in2[0 +: NB] = 32'h4800_0000;
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    chk("first_res_valid", 64'(rv_w[0][0]), 64'(1));
    chk("first_res_data", 64'(rdata_w[0][NB-1:0]), 64'h4800_0000);
    wait_idle();

    // Everyone requesting, everyone popping: full-rate round robin.
    req_valid = '1;
    res_ready = '1;
    for (int c = 0; c < 40; c++) begin
      rnd_ops();
      step();
    end
    wait_idle();

    // Requester 2 alone with its FIFO stalled, then single pops.
    req_valid = 4'b0100;
    res_ready = 4'b1011;
    for (int c = 0; c < 8; c++) begin
      rnd_ops();
      step();
    end
    for (int r = 0; r < 3; r++) begin
      res_ready = 4'b1111;
      step();
      res_ready = 4'b1011;
      repeat (5) step();
    end
    wait_idle();

    // Requesters 1 and 3 alternating with random back-pressure.
    for (int c = 0; c < 30; c++) begin
      req_valid = (c % 2) ? 4'b1000 : 4'b0010;
      res_ready = 4'($urandom);
      rnd_ops();
      step();
    end
    wait_idle();

    // Fully random traffic.
    for (int c = 0; c < 300; c++) begin
      req_valid = 4'($urandom);
      res_ready = 4'($urandom);
      rnd_ops();
      step();
    end
    wait_idle();

    // Spurious done with nothing in flight; flag must stick until reset.
    inj = 1'b1;
    step();
    inj = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("err_sticky_l0", 64'(err_w[0]), 64'(1));
    chk("err_sticky_l3", 64'(err_w[1]), 64'(1));
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // Fill FIFOs with ops still in flight, then reset in mid-operation.
    req_valid = '1;
    res_ready = '0;
    for (int c = 0; c < 7; c++) begin
      rnd_ops();
      step();
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    res_ready = '1;
    for (int c = 0; c < 12; c++) begin
      rnd_ops();
      step();
    end
    wait_idle();
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
